// File: rtl/apb_fifo_master.sv
// -----------------------------------------------------------------------------
// apb_fifo_master
//
// APB-side drain engine for the AHB-to-APB bridge. Pops address/data write
// entries from the read port of the bridge's async FIFO (rclk domain). Issues
// one APB write transfer per entry. Handles pready wait states, pslverr and a
// wait-state timeout.
//
// Ports
//   rclk, rrst_n       read-domain clock, asynchronous active-low reset
//   rempty             FIFO empty flag
//   fifo_rdata         FIFO head data, valid the cycle after rinc
//   fifo_addr          FIFO head address, valid the cycle after rinc
//   rinc               FIFO pop strobe, one-cycle pulse
//   paddr, pwdata      APB address / write data, held through ACCESS
//   pwrite, psel,      APB control
//   penable
//   pready, pslverr    APB slave response
//   busy               high whenever the engine is not IDLE
//   err_count          saturating count of failed (pslverr or timed-out) transfers
//   timeout_err        one-cycle pulse when a transfer is aborted on timeout
//
// Every output is a register. The outputs are decoded from the *next* state, so
// they line up with the state register and do not lag it by a cycle.
// -----------------------------------------------------------------------------
module apb_fifo_master #(
  parameter int DSIZE   = 32,
  parameter int AWIDTH  = 32,
  parameter int PADDR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic               rempty,
  input  logic [DSIZE-1:0]   fifo_rdata,
  input  logic [AWIDTH-1:0]  fifo_addr,
  output logic               rinc,
  output logic [PADDR_W-1:0] paddr,
  output logic [DSIZE-1:0]   pwdata,
  output logic               pwrite,
  output logic               psel,
  output logic               penable,
  input  logic               pready,
  input  logic               pslverr,
  output logic               busy,
  output logic [7:0]         err_count,
  output logic               timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SETUP,
    ACCESS
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             xfer_done;   // ACCESS completed with pready
  logic             xfer_abort;  // ACCESS aborted on timeout
  logic             err_hit;

  // Next-state logic. Completion is tested before the timeout, so pready
  // arriving in the last allowed cycle still counts as a normal completion.
  always_comb begin
    // NOTE: every variable driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    xfer_done    = 1'b0;
    xfer_abort   = 1'b0;

    unique case (state)
      IDLE:   if (!rempty) state_nxt = POP;
      POP:    state_nxt = LOAD;
      LOAD:   state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (pready)                   xfer_done    = 1'b1;
        else if (wait_cnt == CNT_LAST) xfer_abort  = 1'b1;
        else                          wait_cnt_nxt = wait_cnt + 1'b1;

        // rempty is only looked at here, so entries arriving mid-transfer
        // wait for this decision and back-to-back pops skip IDLE entirely.
        if (xfer_done || xfer_abort) begin
          wait_cnt_nxt = '0;
          state_nxt    = rempty ? IDLE : POP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pslverr is only meaningful alongside pready.
  assign err_hit = (xfer_done && pslverr) || xfer_abort;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rinc        <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      rinc        <= (state_nxt == POP);
      psel        <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      pwrite      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable     <= (state_nxt == ACCESS);
      busy        <= (state_nxt != IDLE);
      timeout_err <= xfer_abort;

      // The FIFO presents the popped entry one cycle after rinc (LOAD).
      if (state == LOAD) begin
        paddr  <= fifo_addr[PADDR_W-1:0];
        pwdata <= fifo_rdata;
      end

      if (err_hit && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_fifo_master.sv
// -----------------------------------------------------------------------------
// tb_apb_fifo_master
//
// Self-checking bench for apb_fifo_master. A queue stands in for the async
// FIFO read port. The APB slave answers each transfer after a chosen number of
// wait cycles. A transaction-level model derives the expected outcome of each
// transfer from that choice:
//   - ACCESS length
//   - timeout pulse
//   - error count
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_apb_fifo_master;

  localparam int DSIZE   = 32;
  localparam int AWIDTH  = 32;
  localparam int PADDR_W = 32;
  localparam int TIMEOUT = 16;

  logic               rclk = 1'b0;
  logic               rrst_n;
  logic               rempty;
  logic [DSIZE-1:0]   fifo_rdata;
  logic [AWIDTH-1:0]  fifo_addr;
  logic               rinc;
  logic [PADDR_W-1:0] paddr;
  logic [DSIZE-1:0]   pwdata;
  logic               pwrite;
  logic               psel;
  logic               penable;
  logic               pready;
  logic               pslverr;
  logic               busy;
  logic [7:0]         err_count;
  logic               timeout_err;

  apb_fifo_master #(
    .DSIZE  (DSIZE),
    .AWIDTH (AWIDTH),
    .PADDR_W(PADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rempty     (rempty),
    .fifo_rdata (fifo_rdata),
    .fifo_addr  (fifo_addr),
    .rinc       (rinc),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .pready     (pready),
    .pslverr    (pslverr),
    .busy       (busy),
    .err_count  (err_count),
    .timeout_err(timeout_err)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DSIZE-1:0]  data;
  } entry_t;

  entry_t fifo_q[$];   // entries not yet popped
  int     w_plan[$];   // forced wait counts for upcoming transfers
  int     err_plan[$]; // forced pslverr choice for upcoming transfers

  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     rinc_cyc = -100;
  int     k        = 0;  // ACCESS cycles seen in the current transfer
  int     cur_w    = 0;  // pready rises on ACCESS cycle index cur_w
  int     cur_err  = 0;
  int     exp_err  = 0;
  int     n_xfer   = 0;
  logic   prev_acc = 1'b0;
  logic   prev_rinc = 1'b0;
  entry_t cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [AWIDTH-1:0] a, input logic [DSIZE-1:0] d);
    entry_t e;
    e.addr = a;
    e.data = d;
    fifo_q.push_back(e);
    rempty = 1'b0;
  endtask

  task automatic choose_plan();
    int r;
    if (w_plan.size() != 0) cur_w = w_plan.pop_front();
    else begin
      r = $urandom_range(0, 9);
      if (r < 6)       cur_w = r % 4;
      else if (r == 6) cur_w = TIMEOUT - 1;
      else if (r == 7) cur_w = TIMEOUT;
      else             cur_w = $urandom_range(4, 30);
    end
    if (err_plan.size() != 0) cur_err = err_plan.pop_front();
    else                      cur_err = $urandom_range(0, 1);
  endtask

  // One clock cycle: observe at the falling edge, update the model, drive.
  task automatic tick();
    logic acc;
    int   exp_len;
    logic exp_to;
    @(negedge rclk);
    cyc++;
    acc = psel && penable;

    // Transfer just finished: judge it against the model.
    if (prev_acc && !acc) begin
      exp_to  = (cur_w >= TIMEOUT);
      exp_len = exp_to ? TIMEOUT : cur_w + 1;
      if (exp_to || cur_err != 0) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
      n_xfer++;
      check("access_len", k, exp_len);
      check("timeout_err", timeout_err, exp_to);
      check("err_count", err_count, exp_err);
      check("next_pop", rinc, !rempty);
      check("busy_after", busy, !rempty);
    end else begin
      check("timeout_quiet", timeout_err, 1'b0);
    end

    if (rinc) begin
      check("rinc_empty", rempty, 1'b0);
      check("rinc_psel", psel, 1'b0);
      check("rinc_width", prev_rinc, 1'b0);
      rinc_cyc = cyc;
      if (fifo_q.size() != 0) begin
        cur        = fifo_q.pop_front();
        fifo_addr  = cur.addr;
        fifo_rdata = cur.data;
      end
      rempty = (fifo_q.size() == 0);
    end

    if (psel && !penable) begin
      check("setup_gap", cyc - rinc_cyc, 2);
      check("setup_paddr", paddr, cur.addr[PADDR_W-1:0]);
      check("setup_pwdata", pwdata, cur.data);
      check("setup_pwrite", pwrite, 1'b1);
      k = 0;
      choose_plan();
    end

    if (acc) begin
      if (paddr !== cur.addr[PADDR_W-1:0] || pwdata !== cur.data) begin
        check("access_paddr", paddr, cur.addr[PADDR_W-1:0]);
        check("access_pwdata", pwdata, cur.data);
      end
      pready  = (k >= cur_w);
      pslverr = pready ? cur_err[0] : 1'($urandom);
      k++;
    end else begin
      // Outside ACCESS the slave response must be ignored.
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
    end

    prev_acc  = acc;
    prev_rinc = rinc;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(fifo_q.size() == 0 && !busy && !prev_acc) && n < max_cycles);
    if (n >= max_cycles) check("drain_bound", 32'd0, 32'd1);
  endtask

  initial begin
    int start_xfer;
    rrst_n     = 1'b0;
    rempty     = 1'b1;
    pready     = 1'b0;
    pslverr    = 1'b0;
    fifo_addr  = '0;
    fifo_rdata = '0;
    #12;
    check("rst_rinc", rinc, 1'b0);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_err", err_count, 8'd0);
    check("rst_timeout", timeout_err, 1'b0);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Single entry, zero wait states.
    w_plan.push_back(0);
    err_plan.push_back(0);
    push(32'h0000_0040, 32'hDEAD_BEEF);
    wait_idle(50);
    check("single_xfers", n_xfer, 1);

    // Three queued entries back to back.
    repeat (3) begin
      w_plan.push_back(0);
      err_plan.push_back(0);
    end
    push(32'h0000_1000, 32'h1111_1111);
    push(32'h0000_2004, 32'h2222_2222);
    push(32'h0000_3008, 32'h3333_3333);
    wait_idle(60);
    check("triple_xfers", n_xfer, 4);

    // Three wait states then pslverr.
    w_plan.push_back(3);
    err_plan.push_back(1);
    push(32'hA5A5_0010, 32'hCAFE_F00D);
    wait_idle(60);

    // Timeout, then ready exactly on the last allowed cycle, then a normal one.
    w_plan.push_back(TIMEOUT + 5);
    err_plan.push_back(0);
    w_plan.push_back(TIMEOUT - 1);
    err_plan.push_back(0);
    w_plan.push_back(0);
    err_plan.push_back(0);
    push(32'h0000_0100, 32'h0BAD_0001);
    push(32'h0000_0104, 32'h0BAD_0002);
    push(32'h0000_0108, 32'h0BAD_0003);
    wait_idle(200);

    // Saturation: 256 failing completions.
    for (int i = 0; i < 256; i++) begin
      w_plan.push_back(0);
      err_plan.push_back(1);
      push(32'h0001_0000 + 32'(i * 4), 32'($urandom));
    end
    wait_idle(2000);
    check("err_saturated", err_count, 8'd255);

    // Reset during ACCESS: in-flight entry dropped, the rest drained once.
    w_plan.push_back(5);
    err_plan.push_back(0);
    push(32'h0000_0A00, 32'hAAAA_0000);
    push(32'h0000_0A04, 32'hAAAA_0001);
    push(32'h0000_0A08, 32'hAAAA_0002);
    for (int i = 0; i < 20 && !(psel && penable); i++) tick();
    check("reach_access", psel && penable, 1'b1);
    rrst_n = 1'b0;
    #1;
    check("midrst_psel", psel, 1'b0);
    check("midrst_penable", penable, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_err", err_count, 8'd0);
    check("midrst_rinc", rinc, 1'b0);
    @(posedge rclk);
    #2;
    rrst_n    = 1'b1;
    prev_acc  = 1'b0;
    prev_rinc = 1'b0;
    rinc_cyc  = -100;
    exp_err   = 0;
    start_xfer = n_xfer;
    wait_idle(200);
    check("post_rst_xfers", n_xfer - start_xfer, 2);

    // Empty FIFO: engine stays idle.
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rinc !== 1'b0 || busy !== 1'b0) begin
        check("idle_rinc", rinc, 1'b0);
        check("idle_busy", busy, 1'b0);
      end
    end
    check("idle_end_rinc", rinc, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) push(32'($urandom), 32'($urandom));
      end
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle(5000);
    check("final_err", err_count, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_fifo_master.md
Name: apb_fifo_master

Overview:
- APB-side drain engine for the AHB-to-APB bridge.
- Pops write entries (address + data) from the read port of the bridge's async FIFO in the rclk domain and issues one APB write transfer per entry.
- Handles pready wait states, pslverr, and a wait-state timeout.
- Provides the handshake (rinc/rempty) that the FIFO read side expects.

Parameters:
DSIZE, 32, width of FIFO data and pwdata
AWIDTH, 32, width of FIFO address entry
PADDR_W, 32, width of paddr (≤ AWIDTH; lower bits of the FIFO address)
TIMEOUT, 16, max ACCESS cycles with pready low before abort (≥2)

Ports:
rclk  input  1  APB/read-domain clock
rrst_n  input  1  asynchronous active-low reset
rempty  input  1  FIFO empty flag (rclk domain)
fifo_rdata  input  DSIZE  FIFO head data, registered by FIFO on rinc
fifo_addr  input  AWIDTH  FIFO head address, registered by FIFO on rinc
rinc  output  1  FIFO pop strobe, one-cycle pulse
paddr  output  PADDR_W  APB address
pwdata  output  DSIZE  APB write data
pwrite  output  1  APB direction, 1 during every transfer
psel  output  1  APB select
penable  output  1  APB enable
pready  input  1  APB slave ready
pslverr  input  1  APB slave error, sampled only with pready in ACCESS
busy  output  1  high in any state other than IDLE
err_count  output  8  saturating count of failed transfers
timeout_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rrst_n=0):
  - State = IDLE.
  - rinc, psel, penable, pwrite, busy, timeout_err = 0.
  - paddr, pwdata, err_count = 0.
  - Wait counter = 0.
- All outputs are registered; state machine is single-clock on rclk rising edge.
- States:
  - IDLE: rinc=0. If rempty=0 → POP.
  - POP: rinc=1 for exactly this cycle → LOAD.
  - LOAD: fifo_addr/fifo_rdata are valid (FIFO read latency is 1 cycle after rinc).
    - Capture paddr = fifo_addr[PADDR_W-1:0] and pwdata = fifo_rdata.
    - → SETUP.
  - SETUP: psel=1, penable=0, pwrite=1 → ACCESS.
  - ACCESS: psel=1, penable=1. Wait counter increments each cycle pready=0.
    - pready=1: transfer completes.
      - If pslverr=1, err_count += 1 (saturates at 255).
      - Clear wait counter.
      - If rempty=0 → POP, else → IDLE. psel and penable drop the next cycle in both cases.
    - pready=0 and wait counter reaches TIMEOUT-1: abort.
      - psel and penable drop next cycle; timeout_err pulses one cycle.
      - err_count += 1 (saturating); clear counter.
      - Next state follows the same rempty rule as completion.
    - pready=1 in the same cycle the timeout would fire: completion wins; no timeout_err.
- paddr and pwdata are held stable from SETUP through the end of ACCESS. They keep their last values in IDLE.
- Minimum transfer period: 4 cycles (POP, LOAD, SETUP, ACCESS). Back-to-back entries run with no IDLE cycle.
- rinc is never asserted while rempty=1. At most one pop per transfer. No pop while psel=1.
- rempty going low in any non-IDLE state is ignored until the completion decision.
- Reset mid-transfer: outputs clear immediately. Any entry already popped is discarded; there is no replay.
- err_count is cleared only by reset.

Test Plan:
- Single entry (addr 0x0000_0040, data 0xDEAD_BEEF), pready tied 1 → rinc pulses once; SETUP: psel=1, penable=0, paddr=0x40, pwdata=0xDEADBEEF; ACCESS one cycle later; psel=0 after; busy returns 0; err_count=0.
- Three queued entries, pready=1 → three transfers, 4 cycles each, rinc every 4th cycle, no IDLE in between; addresses and data in FIFO order.
- One entry, pready low 3 ACCESS cycles then high with pslverr=1 → paddr/pwdata stable for 4 ACCESS cycles; err_count=1; no timeout_err.
- pready held 0, TIMEOUT=16 → abort after 16 ACCESS cycles; timeout_err high exactly 1 cycle; err_count=1; next queued entry is then popped normally.
- rrst_n pulsed low during ACCESS → psel, penable, busy, err_count = 0 immediately; after release, the engine pops the next remaining entry only, and the aborted entry is not retried.
- 256 pslverr completions → err_count saturates at 255; rempty=1 throughout IDLE → rinc never asserted.
